onchip_memory_arbiter: RTL and testbench
========================================

# onchip_memory_arbiter

Two-master Avalon-MM arbiter that sits directly upstream of the single-port on-chip memory and multiplexes the Nios II data master (m0) and the DMA master (m1) onto its one slave port. It grants one access per cycle with round-robin fairness, tracks the memory's fixed one-cycle read latency, and routes read data back to the issuing master. Accesses beyond the populated depth are absorbed and flagged without reaching the memory.

## Interface
Parameters:
- DEPTH, 8000, number of populated 32-bit words; word addresses >= DEPTH are out of range
- ADDR_W, 13, word-address width on all ports

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high reset
- m0_address / m1_address  in  ADDR_W  word address
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request (read and write never both high on one master)
- m0_byteenable / m1_byteenable  in  4  byte lanes for writes
- m0_writedata / m1_writedata  in  32  write data
- m0_waitrequest / m1_waitrequest  out  1  request not accepted this cycle
- m0_readdata / m1_readdata  out  32  read return data
- m0_readdatavalid / m1_readdatavalid  out  1  readdata valid this cycle
- mem_address  out  ADDR_W  to memory address
- mem_chipselect  out  1  to memory chipselect
- mem_write  out  1  to memory write
- mem_byteenable  out  4  to memory byteenable
- mem_writedata  out  32  to memory writedata
- mem_clken  out  1  to memory clken; equals ~reset
- mem_reset_req  out  1  tied 0
- mem_readdata  in  32  from memory, valid one cycle after a read is presented
- oor_error  out  1  one-cycle pulse per accepted out-of-range access

## Operation
- Request on master n: mn_read | mn_write.
- Grant: combinational from requests and registered last_grant. Only one requester -> it wins. Both -> the master not equal to last_grant wins. last_grant updates to the winner on every accepted access.
- Granted master: waitrequest=0, access accepted this cycle. Any other requesting master: waitrequest=1, must hold its signals. A non-requesting master sees waitrequest=0.
- In-range accepted access: mem_* driven from winner's signals, mem_chipselect=1. No grant -> mem_chipselect=0, mem_write=0, other mem_* don't-care.
- Out-of-range accepted access (address >= DEPTH): mem_chipselect=0; write discarded; read returns 32'h0000_0000; oor_error pulses in the acceptance cycle.
- Read tracking: registers rd_pend, rd_owner, rd_oor set in the acceptance cycle. Next cycle: owner's readdatavalid=1; readdata = rd_oor ? 0 : mem_readdata. Non-owner readdatavalid=0.
- Both mn_readdata ports carry the same mux output; only readdatavalid qualifies.
- Writes produce no response.

## Timing
- Reset (async assert, sync release): m0/m1_waitrequest=1, readdatavalid=0, readdata=0, mem_chipselect=0, mem_write=0, mem_clken=0, oor_error=0, rd_pend=0, last_grant=m1 (so m0 wins the first conflict).
- Throughput: one accepted access per cycle, back-to-back, any mix of masters.
- Read latency: readdatavalid exactly 1 cycle after acceptance; never stalled.
- Simultaneous events: return of a read to one master in the same cycle another access is accepted is legal and independent. Read-after-write to the same address from either master on consecutive cycles returns the new data.
- Reset mid-operation: pending read is dropped, no readdatavalid after reset release; requests held across reset are re-arbitrated from last_grant=m1.
- Address DEPTH-1 is in range; DEPTH through 2^ADDR_W-1 are out of range.

## Test plan
- Reset release, m0 write 0xA5A5_1234 to addr 5 with byteenable 4'hF, then m0 read addr 5 -> no waitrequest; readdatavalid on m0 one cycle after the read accept with 0xA5A5_1234.
- m0 and m1 both read continuously from addr 10 and 20 -> accepts alternate m0, m1, m0, …; each readdatavalid goes to the correct master with correct data; m1 waitrequest high on m0's cycles and vice versa.
- m1 write 0x1111_1111 to addr 7, then m0 write byteenable 4'b0010 data 0x0000_AB00 to addr 7, then m1 reads addr 7 -> returns 0x1111_AB11.
- m0 read addr 8000 and write addr 8191 -> mem_chipselect stays 0, oor_error pulses twice, read returns 0x0000_0000 with readdatavalid; addr 7999 read reaches memory.
- m1 read accepted, reset asserted before the return cycle -> no m1_readdatavalid ever; after release with both requesting, m0 is granted first.

Source files
------------

// File: rtl/onchip_memory_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM.
// Tracks the one-cycle read latency and absorbs out-of-range accesses.
module onchip_memory_arbiter #(
  parameter int DEPTH  = 8000,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [3:0]        m0_byteenable,
  input  logic [31:0]       m0_writedata,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [3:0]        m1_byteenable,
  input  logic [31:0]       m1_writedata,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  output logic              mem_reset_req,
  input  logic [31:0]       mem_readdata,
  output logic              oor_error
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  logic              w_req0;
  logic              w_req1;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_acc;
  logic [ADDR_W-1:0] w_addr;
  logic              w_is_wr;
  logic              w_is_rd;
  logic              w_oor;
  logic [31:0]       w_rdata;

  logic r_last_grant;
  logic r_rd_pend;
  logic r_rd_owner;
  logic r_rd_oor;

  assign w_req0 = (m0_read | m0_write) & ~reset;
  assign w_req1 = (m1_read | m1_write) & ~reset;

  // r_last_grant: 0 = m0, 1 = m1; on conflict the other one wins
  assign w_gnt0 = w_req0 & (~w_req1 | r_last_grant);
  assign w_gnt1 = w_req1 & (~w_req0 | ~r_last_grant);
  assign w_acc  = w_gnt0 | w_gnt1;

  assign w_addr  = w_gnt1 ? m1_address : m0_address;
  assign w_is_wr = w_gnt1 ? m1_write   : m0_write;
  assign w_is_rd = w_gnt1 ? m1_read    : m0_read;
  assign w_oor   = {1'b0, w_addr} >= LP_DEPTH;

  assign m0_waitrequest = reset | (w_req0 & ~w_gnt0);
  assign m1_waitrequest = reset | (w_req1 & ~w_gnt1);

  assign mem_address    = w_addr;
  assign mem_chipselect = w_acc & ~w_oor;
  assign mem_write      = w_acc & ~w_oor & w_is_wr;
  assign mem_byteenable = w_gnt1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = w_gnt1 ? m1_writedata  : m0_writedata;
  assign mem_clken      = ~reset;
  assign mem_reset_req  = 1'b0;
  assign oor_error      = w_acc & w_oor;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_rd_pend    <= 1'b0;
      r_rd_owner   <= 1'b0;
      r_rd_oor     <= 1'b0;
    end else begin
      if (w_acc) begin
        r_last_grant <= w_gnt1;
      end
      r_rd_pend  <= w_acc & w_is_rd;
      r_rd_owner <= w_gnt1;
      r_rd_oor   <= w_oor;
    end
  end

  assign w_rdata = (r_rd_pend & ~r_rd_oor) ? mem_readdata : 32'h0;

  assign m0_readdata      = w_rdata;
  assign m1_readdata      = w_rdata;
  assign m0_readdatavalid = r_rd_pend & ~r_rd_owner;
  assign m1_readdatavalid = r_rd_pend & r_rd_owner;

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Directed bench for onchip_memory_arbiter with a 1-cycle RAM model.
// Inputs change #1 after posedge; outputs are sampled on negedge.
module tb_onchip_memory_arbiter;

  localparam int AW = 13;

  logic          clk;
  logic          reset;
  logic [AW-1:0] m0_address;
  logic          m0_read;
  logic          m0_write;
  logic [3:0]    m0_byteenable;
  logic [31:0]   m0_writedata;
  logic          m0_waitrequest;
  logic [31:0]   m0_readdata;
  logic          m0_readdatavalid;
  logic [AW-1:0] m1_address;
  logic          m1_read;
  logic          m1_write;
  logic [3:0]    m1_byteenable;
  logic [31:0]   m1_writedata;
  logic          m1_waitrequest;
  logic [31:0]   m1_readdata;
  logic          m1_readdatavalid;
  logic [AW-1:0] mem_address;
  logic          mem_chipselect;
  logic          mem_write;
  logic [3:0]    mem_byteenable;
  logic [31:0]   mem_writedata;
  logic          mem_clken;
  logic          mem_reset_req;
  logic [31:0]   mem_readdata;
  logic          oor_error;

  int n_cmp;
  int n_err;

  logic [31:0] ram [0:(1<<AW)-1];

  onchip_memory_arbiter #(
    .DEPTH (8000),
    .ADDR_W(AW)
  ) u_dut (
    .clk             (clk),
    .reset           (reset),
    .m0_address      (m0_address),
    .m0_read         (m0_read),
    .m0_write        (m0_write),
    .m0_byteenable   (m0_byteenable),
    .m0_writedata    (m0_writedata),
    .m0_waitrequest  (m0_waitrequest),
    .m0_readdata     (m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address      (m1_address),
    .m1_read         (m1_read),
    .m1_write        (m1_write),
    .m1_byteenable   (m1_byteenable),
    .m1_writedata    (m1_writedata),
    .m1_waitrequest  (m1_waitrequest),
    .m1_readdata     (m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address     (mem_address),
    .mem_chipselect  (mem_chipselect),
    .mem_write       (mem_write),
    .mem_byteenable  (mem_byteenable),
    .mem_writedata   (mem_writedata),
    .mem_clken       (mem_clken),
    .mem_reset_req   (mem_reset_req),
    .mem_readdata    (mem_readdata),
    .oor_error       (oor_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) begin
            ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
          end
        end
      end
      mem_readdata <= ram[mem_address];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    m0_read  = 1'b0;
    m0_write = 1'b0;
    m1_read  = 1'b0;
    m1_write = 1'b0;
  endtask

  task automatic m0_req(input logic rd, input logic [AW-1:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    m0_read       = rd;
    m0_write      = ~rd;
    m0_address    = a;
    m0_byteenable = be;
    m0_writedata  = d;
  endtask

  task automatic m1_req(input logic rd, input logic [AW-1:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    m1_read       = rd;
    m1_write      = ~rd;
    m1_address    = a;
    m1_byteenable = be;
    m1_writedata  = d;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    mem_readdata = 32'h0;
    reset = 1'b1;
    m0_address = '0;
    m1_address = '0;
    m0_byteenable = 4'h0;
    m1_byteenable = 4'h0;
    m0_writedata = 32'h0;
    m1_writedata = 32'h0;
    idle();
    m0_read = 1'b1;

    // reset state, with a request held
    @(negedge clk);
    chk("rst_m0_wait", {31'b0, m0_waitrequest}, 32'd1);
    chk("rst_m1_wait", {31'b0, m1_waitrequest}, 32'd1);
    chk("rst_m0_rdv",  {31'b0, m0_readdatavalid}, 32'd0);
    chk("rst_m1_rdv",  {31'b0, m1_readdatavalid}, 32'd0);
    chk("rst_rdata",   m0_readdata, 32'h0);
    chk("rst_cs",      {31'b0, mem_chipselect}, 32'd0);
    chk("rst_we",      {31'b0, mem_write}, 32'd0);
    chk("rst_clken",   {31'b0, mem_clken}, 32'd0);
    chk("rst_oor",     {31'b0, oor_error}, 32'd0);
    chk("rst_rreq",    {31'b0, mem_reset_req}, 32'd0);
    nxt();
    idle();
    reset = 1'b0;

    // write then read back on m0
    m0_req(1'b0, 13'd5, 4'hF, 32'hA5A5_1234);
    @(negedge clk);
    chk("t1_clken", {31'b0, mem_clken}, 32'd1);
    chk("t1_wait",  {31'b0, m0_waitrequest}, 32'd0);
    chk("t1_cs",    {31'b0, mem_chipselect}, 32'd1);
    chk("t1_we",    {31'b0, mem_write}, 32'd1);
    chk("t1_addr",  {19'b0, mem_address}, 32'd5);
    chk("t1_wd",    mem_writedata, 32'hA5A5_1234);
    nxt();
    m0_req(1'b1, 13'd5, 4'hF, 32'h0);
    @(negedge clk);
    chk("t1r_wait", {31'b0, m0_waitrequest}, 32'd0);
    chk("t1r_cs",   {31'b0, mem_chipselect}, 32'd1);
    chk("t1r_we",   {31'b0, mem_write}, 32'd0);
    chk("t1r_rdv0", {31'b0, m0_readdatavalid}, 32'd0);
    nxt();
    idle();
    @(negedge clk);
    chk("t1_rdv0", {31'b0, m0_readdatavalid}, 32'd1);
    chk("t1_rdv1", {31'b0, m1_readdatavalid}, 32'd0);
    chk("t1_data", m0_readdata, 32'hA5A5_1234);
    nxt();

    // preload 10 and 20, then both masters read continuously
    m0_req(1'b0, 13'd10, 4'hF, 32'h1010_1010);
    nxt();
    idle();
    m1_req(1'b0, 13'd20, 4'hF, 32'h2020_2020);
    nxt();
    m0_req(1'b1, 13'd10, 4'hF, 32'h0);
    m1_req(1'b1, 13'd20, 4'hF, 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_m0_wait", {31'b0, m0_waitrequest}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr_m1_wait", {31'b0, m1_waitrequest}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_addr", {19'b0, mem_address}, (k % 2 == 0) ? 32'd10 : 32'd20);
      if (k > 0) begin
        chk("rr_rdv0", {31'b0, m0_readdatavalid}, (k % 2 == 1) ? 32'd1 : 32'd0);
        chk("rr_rdv1", {31'b0, m1_readdatavalid}, (k % 2 == 0) ? 32'd1 : 32'd0);
        chk("rr_data", m0_readdata,
            (k % 2 == 1) ? 32'h1010_1010 : 32'h2020_2020);
      end
      nxt();
    end
    idle();
    @(negedge clk);
    chk("rr_last_rdv1", {31'b0, m1_readdatavalid}, 32'd1);
    chk("rr_last_data", m1_readdata, 32'h2020_2020);
    nxt();

    // byte-lane merge and read-after-write
    m1_req(1'b0, 13'd7, 4'hF, 32'h1111_1111);
    nxt();
    idle();
    m0_req(1'b0, 13'd7, 4'b0010, 32'h0000_AB00);
    @(negedge clk);
    chk("be_be", {28'b0, mem_byteenable}, 32'h2);
    nxt();
    idle();
    m1_req(1'b1, 13'd7, 4'hF, 32'h0);
    nxt();
    idle();
    @(negedge clk);
    chk("be_rdv1", {31'b0, m1_readdatavalid}, 32'd1);
    chk("be_rdv0", {31'b0, m0_readdatavalid}, 32'd0);
    chk("be_data", m1_readdata, 32'h1111_AB11);
    nxt();

    // out-of-range boundaries
    m0_req(1'b1, 13'd8000, 4'hF, 32'h0);
    @(negedge clk);
    chk("oor_rd_cs",  {31'b0, mem_chipselect}, 32'd0);
    chk("oor_rd_err", {31'b0, oor_error}, 32'd1);
    chk("oor_rd_wt",  {31'b0, m0_waitrequest}, 32'd0);
    nxt();
    m0_req(1'b0, 13'd8191, 4'hF, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("oor_wr_cs",  {31'b0, mem_chipselect}, 32'd0);
    chk("oor_wr_we",  {31'b0, mem_write}, 32'd0);
    chk("oor_wr_err", {31'b0, oor_error}, 32'd1);
    chk("oor_rdv",    {31'b0, m0_readdatavalid}, 32'd1);
    chk("oor_data",   m0_readdata, 32'h0);
    nxt();
    m0_req(1'b1, 13'd7999, 4'hF, 32'h0);
    @(negedge clk);
    chk("edge_cs",   {31'b0, mem_chipselect}, 32'd1);
    chk("edge_err",  {31'b0, oor_error}, 32'd0);
    chk("edge_addr", {19'b0, mem_address}, 32'd7999);
    chk("edge_rdv",  {31'b0, m0_readdatavalid}, 32'd0);
    nxt();
    idle();
    @(negedge clk);
    chk("edge_rdv_ret", {31'b0, m0_readdatavalid}, 32'd1);
    chk("edge_err_off", {31'b0, oor_error}, 32'd0);
    nxt();

    // reset drops a pending read; re-arbitration after release
    m1_req(1'b1, 13'd7, 4'hF, 32'h0);
    nxt();
    reset = 1'b1;
    m0_req(1'b1, 13'd5, 4'hF, 32'h0);
    m1_req(1'b1, 13'd7, 4'hF, 32'h0);
    @(negedge clk);
    chk("mr_rdv1", {31'b0, m1_readdatavalid}, 32'd0);
    chk("mr_wt0",  {31'b0, m0_waitrequest}, 32'd1);
    chk("mr_wt1",  {31'b0, m1_waitrequest}, 32'd1);
    nxt();
    reset = 1'b0;
    @(negedge clk);
    chk("ar_wt0",  {31'b0, m0_waitrequest}, 32'd0);
    chk("ar_wt1",  {31'b0, m1_waitrequest}, 32'd1);
    chk("ar_rdv1", {31'b0, m1_readdatavalid}, 32'd0);
    chk("ar_rdv0", {31'b0, m0_readdatavalid}, 32'd0);
    nxt();
    @(negedge clk);
    chk("ar2_wt0",  {31'b0, m0_waitrequest}, 32'd1);
    chk("ar2_wt1",  {31'b0, m1_waitrequest}, 32'd0);
    chk("ar2_rdv0", {31'b0, m0_readdatavalid}, 32'd1);
    chk("ar2_data", m0_readdata, 32'hA5A5_1234);
    nxt();
    idle();
    @(negedge clk);
    chk("ar3_rdv1", {31'b0, m1_readdatavalid}, 32'd1);
    chk("ar3_data", m1_readdata, 32'h1111_AB11);
    nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
